// File: rtl/data_mem_responder.sv
// Data-port responder for the single-cycle core: word RAM plus STATUS/TXDATA/TIMER
// registers. Reads are combinational; writes, FIFO and timer update on the rising edge.
module data_mem_responder #(
  parameter int bus         = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [bus-1:0] memdir,
  input  logic [bus-1:0] memdataout,
  input  logic           MRE,
  input  logic           MWE,
  output logic [bus-1:0] memdatain,
  output logic [bus-1:0] tx_data,
  output logic           tx_valid,
  input  logic           tx_ready
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [bus-1:0] RAM_LIMIT   = bus'(DEPTH_WORDS * 4);
  localparam logic [bus-1:0] WORD_MASK   = ~bus'(3);
  localparam logic [bus-1:0] STATUS_ADDR = bus'(32'h0000_1000);
  localparam logic [bus-1:0] TXDATA_ADDR = bus'(32'h0000_1004);
  localparam logic [bus-1:0] TIMER_ADDR  = bus'(32'h0000_1008);
  localparam logic [CW-1:0]  COUNT_FULL  = CW'(FIFO_DEPTH);

  logic [bus-1:0] ram_q  [DEPTH_WORDS];
  logic [bus-1:0] fifo_q [FIFO_DEPTH];

  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ovf_q, ovf_d;
  logic           decerr_q, decerr_d;
  logic [bus-1:0] timer_q, timer_d;

  logic [bus-1:0] addr_w;
  logic [AW-1:0]  ram_idx;
  logic           hit_ram, hit_status, hit_tx, hit_timer, unmapped;
  logic           empty, full, pop, push_req, push_ok;
  logic           status_wr, ram_we;
  logic [bus-1:0] status_word;

  // Address decode: low two byte-address bits never affect the register match.
  always_comb begin
    addr_w     = memdir & WORD_MASK;
    ram_idx    = memdir[AW+1:2];
    hit_ram    = (memdir < RAM_LIMIT);
    hit_status = !hit_ram && (addr_w == STATUS_ADDR);
    hit_tx     = !hit_ram && (addr_w == TXDATA_ADDR);
    hit_timer  = !hit_ram && (addr_w == TIMER_ADDR);
    unmapped   = !(hit_ram || hit_status || hit_tx || hit_timer);
  end

  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == COUNT_FULL);
    tx_valid  = !empty;
    tx_data   = empty ? '0 : fifo_q[rd_ptr_q];
    pop       = tx_valid & tx_ready;
    push_req  = MWE & hit_tx;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    push_ok   = push_req & (!full | pop);
    status_wr = MWE & hit_status;
    ram_we    = MWE & hit_ram & !reset;
    status_word = bus'({8'(count_q), 4'b0000, decerr_q, ovf_q, full, empty});
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    decerr_d = decerr_q;
    timer_d  = timer_q + bus'(1);

    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (push_req && !push_ok)            ovf_d    = 1'b1;
    if (status_wr && memdataout[2])      ovf_d    = 1'b0;
    if ((MRE || MWE) && unmapped)        decerr_d = 1'b1;
    if (status_wr && memdataout[3])      decerr_d = 1'b0;
    if (MWE && hit_timer)                timer_d  = memdataout;
  end

  // Read mux sees only registered state, so a same-cycle write returns the old value.
  always_comb begin
    memdatain = '0;
    if (MRE) begin
      if (hit_ram)         memdatain = ram_q[ram_idx];
      else if (hit_status) memdatain = status_word;
      else if (hit_tx)     memdatain = tx_data;
      else if (hit_timer)  memdatain = timer_q;
      else                 memdatain = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      decerr_q <= 1'b0;
      timer_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      decerr_q <= decerr_d;
      timer_q  <= timer_d;
    end
  end

  // Storage arrays carry no reset; FIFO validity is governed by count alone.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= memdataout;
    if (push_ok && !reset) fifo_q[wr_ptr_q] <= memdataout;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: read-data scoreboard plus a reference FIFO queue.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] memdir, memdataout, memdatain, tx_data;
  logic        MRE, MWE, tx_valid, tx_ready;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] fifo_model[$];

  always #5 clk = ~clk;

  data_mem_responder #(.bus(32), .DEPTH_WORDS(256), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .memdir(memdir), .memdataout(memdataout),
    .MRE(MRE), .MWE(MWE), .memdatain(memdatain), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rd_en, input logic wr_en, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy);
    @(negedge clk);
    MRE = rd_en; MWE = wr_en; memdir = a; memdataout = d; tx_ready = rdy;
  endtask

  task automatic expect_rd(input string tag, input logic [31:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic sample_rd();
    #2;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $error("FAIL scoreboard_empty observed=%h expected=none", memdatain);
    end else begin
      cmp(tag_q.pop_front(), memdatain, exp_q.pop_front());
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] e);
    drive(1'b1, 1'b0, a, 32'h0, 1'b0);
    expect_rd(tag, e);
    sample_rd();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, a, d, 1'b0);
  endtask

  task automatic push_tx(input logic [31:0] d);
    wr(32'h1004, d);
    fifo_model.push_back(d);
  endtask

  task automatic drain(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      #2;
      cmp({tag, "_valid"}, {31'b0, tx_valid}, 32'd1);
      if (fifo_model.size() != 0) cmp({tag, "_data"}, tx_data, fifo_model.pop_front());
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    #2;
    cmp({tag, "_empty_valid"}, {31'b0, tx_valid}, 32'd0);
    cmp({tag, "_empty_data"}, tx_data, 32'd0);
  endtask

  initial begin
    reset = 1'b1; MRE = 1'b0; MWE = 1'b0; tx_ready = 1'b0;
    memdir = 32'h0; memdataout = 32'h0;
    repeat (2) @(negedge clk);
    MRE = 1'b1; memdir = 32'h1000;
    #1;
    cmp("rst_valid", {31'b0, tx_valid}, 32'd0);
    cmp("rst_data", tx_data, 32'd0);
    cmp("rst_status", memdatain, 32'h0000_0001);
    @(negedge clk);
    reset = 1'b0; MRE = 1'b0;

    // RAM access, read gating, same-cycle read/write, last RAM word.
    wr(32'h10, 32'hDEAD_BEEF);
    rd("ram_rd", 32'h10, 32'hDEAD_BEEF);
    drive(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    expect_rd("ram_mre0", 32'h0);
    sample_rd();
    drive(1'b1, 1'b1, 32'h10, 32'hCAFE_F00D, 1'b0);
    expect_rd("ram_rw_old", 32'hDEAD_BEEF);
    sample_rd();
    rd("ram_rw_new", 32'h10, 32'hCAFE_F00D);
    wr(32'h3FC, 32'h1234_5678);
    rd("ram_last", 32'h3FE, 32'h1234_5678);

    // Fill, overflow, drain.
    for (int i = 1; i <= 8; i++) push_tx(32'(i));
    rd("st_full", 32'h1000, 32'h0000_0802);
    rd("txdata_rd", 32'h1004, 32'h1);
    wr(32'h1004, 32'h9);
    rd("st_ovf", 32'h1000, 32'h0000_0806);
    drain(8, "drain1");
    rd("st_drained", 32'h1000, 32'h0000_0005);
    wr(32'h1000, 32'h4);
    rd("st_ovf_clr", 32'h1000, 32'h0000_0001);

    // Push into a full FIFO while the head is popped.
    for (int i = 0; i < 8; i++) push_tx(32'h11 + 32'(i));
    drive(1'b0, 1'b1, 32'h1004, 32'h55, 1'b1);
    #2;
    cmp("fp_head", tx_data, fifo_model.pop_front());
    fifo_model.push_back(32'h55);
    rd("st_fp", 32'h1000, 32'h0000_0802);
    drain(8, "drain2");

    // Timer load, wrap, same-cycle read/write.
    wr(32'h1008, 32'hFFFF_FFFE);
    rd("tmr0", 32'h1008, 32'hFFFF_FFFE);
    rd("tmr1", 32'h1008, 32'hFFFF_FFFF);
    rd("tmr2", 32'h1008, 32'h0000_0000);
    rd("tmr3", 32'h1008, 32'h0000_0001);
    drive(1'b1, 1'b1, 32'h1008, 32'h100, 1'b0);
    expect_rd("tmr_rw_old", 32'h2);
    sample_rd();
    rd("tmr_loaded", 32'h1008, 32'h100);

    // Decode errors and write-1-to-clear.
    rd("unmapped_rd", 32'h2000, 32'h0);
    rd("st_decerr", 32'h1000, 32'h0000_0009);
    wr(32'h1000, 32'h8);
    rd("st_decerr_clr", 32'h1000, 32'h0000_0001);
    wr(32'h1000, 32'h3);
    rd("st_w1c_low", 32'h1000, 32'h0000_0001);
    rd("ram_edge_rd", 32'h400, 32'h0);
    rd("st_edge_decerr", 32'h1000, 32'h0000_0009);
    wr(32'h1000, 32'h8);
    wr(32'h3000, 32'hFF);
    rd("st_wr_decerr", 32'h1000, 32'h0000_0009);
    wr(32'h1000, 32'h8);

    // Asynchronous reset mid-cycle with FIFO entries and a pending timer write.
    push_tx(32'hA1); push_tx(32'hA2); push_tx(32'hA3);
    wr(32'h1008, 32'h100);
    @(posedge clk);
    #3;
    MRE = 1'b0; MWE = 1'b1; memdir = 32'h1008; memdataout = 32'h777; reset = 1'b1;
    #1;
    cmp("arst_valid", {31'b0, tx_valid}, 32'd0);
    cmp("arst_data", tx_data, 32'd0);
    fifo_model.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; MWE = 1'b0; MRE = 1'b1; memdir = 32'h1008;
    expect_rd("arst_timer", 32'h0);
    sample_rd();
    rd("arst_status", 32'h1000, 32'h0000_0001);
    rd("arst_ram_kept", 32'h10, 32'hCAFE_F00D);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the single-cycle ARM core's data port. Services the core's MRE/MWE requests on memdir, memdataout and memdatain.
- Contains a word RAM and three memory-mapped registers: STATUS, TXDATA (feeds an outbound FIFO with a valid/ready handshake) and TIMER (free-running counter).
- Reads are combinational, because the core consumes load data in the same cycle. Writes commit on the rising clock edge.

Parameters:
- bus, 32, data/address width.
- DEPTH_WORDS, 256, RAM size in words (power of two, at most 1024).
- FIFO_DEPTH, 8, TX FIFO entries (power of two, at most 128).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- memdir  in  bus  byte address from core ALU; bits [1:0] ignored.
- memdataout  in  bus  write data from core.
- MRE  in  1  read enable.
- MWE  in  1  write enable.
- memdatain  out  bus  read data to core.
- tx_data  out  bus  FIFO head word.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  downstream accepts head this cycle.

Behaviour:
- One clock domain; reset is asynchronous and active-high.
- Address decode uses word address A = memdir[bus-1:2]:
  - RAM: memdir < DEPTH_WORDS*4.
  - STATUS: 0x0000_1000.
  - TXDATA: 0x0000_1004.
  - TIMER: 0x0000_1008.
  - Anything else: unmapped.
- Read path (combinational):
  - MRE=0 -> memdatain = 0.
  - RAM -> word at A.
  - STATUS -> {16'b0, count[7:0], 4'b0, decerr, ovf, full, empty}.
  - TXDATA -> current tx_data.
  - TIMER -> timer.
  - Unmapped -> 0.
- Write path (rising edge, MWE=1):
  - RAM -> word at A <= memdataout.
  - STATUS -> write-1-to-clear: bit2 clears ovf, bit3 clears decerr; other bits ignored.
  - TXDATA -> push memdataout.
  - TIMER -> timer <= memdataout.
  - Unmapped -> no state change.
- MRE and MWE together: the read returns the pre-write value and the write commits at the edge.
- Decode error: an access (MRE or MWE) to an unmapped address sets sticky decerr at the edge.
- RAM contents are not cleared by reset and are undefined until written. The bench must write before it reads.
- TX FIFO:
  - Circular buffer with rd_ptr, wr_ptr and count (0..FIFO_DEPTH).
  - empty = (count==0); full = (count==FIFO_DEPTH).
  - tx_valid = !empty; tx_data = entry at rd_ptr (0 when empty).
  - pop = tx_valid & tx_ready: rd_ptr advances, count decrements.
  - A push is accepted if !full, or if full and pop happens in the same cycle (count unchanged, both pointers advance).
  - A push while full with no pop is dropped and sets ovf (sticky).
  - Push and pop together when not full: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- TIMER:
  - Increments by 1 every cycle and wraps from 0xFFFF_FFFF to 0.
  - A write loads the written value at the edge; increments resume on the next edge.
  - A read in the same cycle as a write returns the old value.
- Reset:
  - Resets timer, pointers, count, ovf and decerr to 0; tx_valid=0, tx_data=0.
  - memdatain follows the decode (0 if MRE=0).
  - Reset mid-transfer discards all FIFO contents; a pending write in that cycle is lost.

Test Plan:
- Write 0xDEADBEEF to 0x10, then read 0x10 with MRE=1 -> memdatain=0xDEADBEEF in the same cycle as the read. Read with MRE=0 -> memdatain=0.
- Push 8 words 1..8 to 0x1004 with tx_ready=0 -> STATUS=0x0000_0802 (count 8, full). Push 9th word -> STATUS bit2 set, FIFO unchanged. Raise tx_ready -> tx_data sequence 1..8, then tx_valid=0 and STATUS=0x0000_0005.
- With FIFO full, push 0x55 while tx_ready=1 -> push accepted, count stays 8, ovf stays 0; 0x55 emerges last.
- Write 0xFFFF_FFFE to 0x1008, then read on the following cycles -> 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000, 0x0000_0001.
- Read 0x2000 -> memdatain=0, STATUS bit3 set. Write 0x8 to 0x1000 -> bit3 cleared. Write 0x3 to 0x1000 -> no change to empty/full.
- Assert reset asynchronously mid-cycle with 3 FIFO entries and timer=0x100 -> tx_valid=0, STATUS=0x0000_0001, TIMER reads 0 immediately after reset release.
